// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg
//   Shared constants and helpers for the RAM-bus responder. This package holds
//   the bus address width, the default I/O base, the I/O register offsets and
//   the status-register bit positions. It also has the bus access decoder and
//   a saturating counter step.
//   The STATS offsets are only decoded when RAM_RESPONDER_STATS_EN is defined.
package ram_responder_pkg;

  localparam int AddressWidth = 32;

  localparam logic [AddressWidth-1:0] IoBaseDefault = 32'h0003_0000;

  // Offsets relative to the I/O base
  localparam logic [AddressWidth-1:0] OffTxData   = 32'd0;
  localparam logic [AddressWidth-1:0] OffStatus   = 32'd4;
  localparam logic [AddressWidth-1:0] OffStatRdLo = 32'd8;
  localparam logic [AddressWidth-1:0] OffStatRdHi = 32'd9;
  localparam logic [AddressWidth-1:0] OffStatWrLo = 32'd10;
  localparam logic [AddressWidth-1:0] OffStatWrHi = 32'd11;
  localparam logic [AddressWidth-1:0] OffStatTxLo = 32'd12;
  localparam logic [AddressWidth-1:0] OffStatTxHi = 32'd13;

  // Status register layout: {overflow, full, empty, 5'b0}
  localparam int StatusOverflowBit = 7;
  localparam int StatusFullBit     = 6;
  localparam int StatusEmptyBit    = 5;

  typedef enum logic [1:0] {
    AccRamRead,
    AccRamWrite,
    AccIoRead,
    AccIoWrite
  } access_e;

  // Anything at or above the I/O base is I/O. Such an address never aliases into RAM.
  function automatic access_e decodeAccess(input logic isWrite,
                                           input logic [AddressWidth-1:0] addr,
                                           input logic [AddressWidth-1:0] ioBase);
    if (addr >= ioBase) return isWrite ? AccIoWrite : AccIoRead;
    return isWrite ? AccRamWrite : AccRamRead;
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ram_responder_tx_byte_fifo.sv
// tx_byte_fifo
//   This is a byte FIFO that feeds the serial transmitter. The head byte is
//   visible combinationally on dout_out. It reads 0 when the FIFO is empty.
//   A push that arrives while the FIFO is full is accepted only when a pop
//   happens in the same cycle. The caller decides whether a refused push
//   counts as an overflow.
// Ports
//   clk_in, rst_in   clock, async active-high reset (empties the FIFO)
//   push_in, din_in  push request and data
//   pop_in           pop request (ignored when empty)
//   dout_out         head byte
//   full_out         DEPTH entries held
//   empty_out        no entries held
module tx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_in,
  input  logic       pop_in,
  input  logic [7:0] din_in,
  output logic [7:0] dout_out,
  output logic       full_out,
  output logic       empty_out
);

  localparam int PtrBits = $clog2(DEPTH);

  logic [PtrBits-1:0] r_wrPtr;
  logic [PtrBits-1:0] r_rdPtr;
  logic [PtrBits:0]   r_count;
  logic [7:0]         r_buf [DEPTH];
  logic               w_doPush;
  logic               w_doPop;

  assign empty_out = (r_count == '0);
  assign full_out  = (r_count == (PtrBits+1)'(DEPTH));
  assign w_doPop   = pop_in && !empty_out;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_doPush  = push_in && (!full_out || w_doPop);
  assign dout_out  = empty_out ? 8'h00 : r_buf[r_rdPtr];

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PtrBits'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PtrBits'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PtrBits+1)'(1);
        2'b01:   r_count <= r_count - (PtrBits+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The storage has no reset. Slots become readable only through the pointers.
  always_ff @(posedge clk_in) begin
    if (w_doPush) r_buf[r_wrPtr] <= din_in;
  end

endmodule

// File: rtl/ram_responder.sv
// ram_responder
//   This is the memory-side responder for the core's byte-wide RAM bus. It
//   serves a byte RAM with a 1-cycle registered read. It also decodes an I/O
//   window at IO_BASE:
//     +0      TX FIFO data (write pushes)
//     +4      status {overflow, full, empty, 5'b0}; a write clears overflow
//     +8..+13 16-bit stat counters, low byte first
//             (only with RAM_RESPONDER_STATS_EN; a write to +8 clears them)
//   RAM addresses wrap modulo 2**ADDR_BITS. The RAM itself is never reset.
// Ports
//   clk_in, rst_in   clock, async active-high reset
//   rdy_in           global enable; nothing changes while low
//   ram_rw_in        1 = write, 0 = read
//   ram_addr_in      byte address
//   ram_data_in      write byte
//   ram_data_out     read byte for the previous cycle's address
//   tx_valid_out     TX FIFO head valid
//   tx_data_out      TX FIFO head byte
//   tx_ready_in      sink accepts the head
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int                      ADDR_BITS = 17,
  parameter logic [AddressWidth-1:0] IO_BASE   = IoBaseDefault,
  parameter int                      TX_DEPTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    ram_rw_in,
  input  logic [AddressWidth-1:0] ram_addr_in,
  input  logic [7:0]              ram_data_in,
  output logic [7:0]              ram_data_out,
  output logic                    tx_valid_out,
  output logic [7:0]              tx_data_out,
  input  logic                    tx_ready_in
);

  access_e                 w_access;
  logic [AddressWidth-1:0] w_offset;
  logic [ADDR_BITS-1:0]    w_ramAddr;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_pushTaken;
  logic                    w_full;
  logic                    w_empty;
  logic [7:0]              w_status;
  logic [7:0]              w_ioData;

  logic [7:0]              r_mem [0:(1<<ADDR_BITS)-1];
  logic [7:0]              r_ramData;
  logic [7:0]              r_ioData;
  logic                    r_selRam;
  logic                    r_overflow;

`ifdef RAM_RESPONDER_STATS_EN
  logic [15:0]             r_cntRamRd;
  logic [15:0]             r_cntRamWr;
  logic [15:0]             r_cntTxPush;
`endif

  assign w_access  = decodeAccess(ram_rw_in, ram_addr_in, IO_BASE);
  assign w_offset  = ram_addr_in - IO_BASE;
  assign w_ramAddr = ram_addr_in[ADDR_BITS-1:0];

  assign w_push      = rdy_in && (w_access == AccIoWrite) && (w_offset == OffTxData);
  assign w_pop       = rdy_in && tx_valid_out && tx_ready_in;
  assign w_pushTaken = w_push && (!w_full || w_pop);

  assign tx_valid_out = !w_empty;

  tx_byte_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_txFifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (w_push),
    .pop_in   (w_pop),
    .din_in   (ram_data_in),
    .dout_out (tx_data_out),
    .full_out (w_full),
    .empty_out(w_empty)
  );

  // The I/O read mux. Unmapped offsets and all writes produce 0.
  always_comb begin
    w_status = 8'h00;
    w_status[StatusOverflowBit] = r_overflow;
    w_status[StatusFullBit]     = w_full;
    w_status[StatusEmptyBit]    = w_empty;
    w_ioData = 8'h00;
    if (w_access == AccIoRead) begin
      case (w_offset)
        OffStatus:   w_ioData = w_status;
`ifdef RAM_RESPONDER_STATS_EN
        OffStatRdLo: w_ioData = r_cntRamRd[7:0];
        OffStatRdHi: w_ioData = r_cntRamRd[15:8];
        OffStatWrLo: w_ioData = r_cntRamWr[7:0];
        OffStatWrHi: w_ioData = r_cntRamWr[15:8];
        OffStatTxLo: w_ioData = r_cntTxPush[7:0];
        OffStatTxHi: w_ioData = r_cntTxPush[15:8];
`endif
        default:     w_ioData = 8'h00;
      endcase
    end
  end

  // The read path is split in two. The RAM half has no reset, so it can map
  // onto block RAM. The select and the I/O byte carry the reset, so
  // ram_data_out is 0 after reset even though RAM contents are undefined.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_selRam <= 1'b0;
      r_ioData <= 8'h00;
    end else if (rdy_in) begin
      r_selRam <= (w_access == AccRamRead);
      r_ioData <= w_ioData;
    end
  end

  // This is the RAM array with its registered read port.
  always_ff @(posedge clk_in) begin
    if (rdy_in && (w_access == AccRamWrite)) r_mem[w_ramAddr] <= ram_data_in;
    if (rdy_in && (w_access == AccRamRead))  r_ramData <= r_mem[w_ramAddr];
  end

  assign ram_data_out = r_selRam ? r_ramData : r_ioData;

  // The overflow flag is sticky. It sets when a push is refused because the
  // FIFO is full and nothing pops. It clears on any write to the status offset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_overflow <= 1'b0;
    end else if (rdy_in) begin
      if (w_push && !w_pushTaken)
        r_overflow <= 1'b1;
      else if ((w_access == AccIoWrite) && (w_offset == OffStatus))
        r_overflow <= 1'b0;
    end
  end

`ifdef RAM_RESPONDER_STATS_EN
  // Saturating activity counters. A write to the first counter byte clears all three.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cntRamRd  <= '0;
      r_cntRamWr  <= '0;
      r_cntTxPush <= '0;
    end else if (rdy_in) begin
      if ((w_access == AccIoWrite) && (w_offset == OffStatRdLo)) begin
        r_cntRamRd  <= '0;
        r_cntRamWr  <= '0;
        r_cntTxPush <= '0;
      end else begin
        if (w_access == AccRamRead)  r_cntRamRd  <= satInc(r_cntRamRd);
        if (w_access == AccRamWrite) r_cntRamWr  <= satInc(r_cntRamWr);
        if (w_pushTaken)             r_cntTxPush <= satInc(r_cntTxPush);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   This bench drives directed bus transactions into ram_responder. Each
//   checked read pushes its expected byte into a queue, and so does each TX
//   byte that should be accepted. A monitor on the falling edge pops these
//   queues when the DUT presents read data or completes a TX handshake.
`timescale 1ns/1ps
module tb_ram_responder;

  localparam logic [31:0] IoBase = 32'h0003_0000;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } rdExp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ram_rw_in;
  logic [31:0] ram_addr_in;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in;

  rdExp_t      rdQ[$];
  logic [7:0]  txQ[$];
  logic        rdTag;
  logic        rdPending;
  int          assertCount = 0;
  int          failCount = 0;

  ram_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .ram_rw_in   (ram_rw_in),
    .ram_addr_in (ram_addr_in),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .tx_valid_out(tx_valid_out),
    .tx_data_out (tx_data_out),
    .tx_ready_in (tx_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle. Inputs change 1ns after the rising edge, and the transaction takes effect on the next edge.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [7:0] data,
                               input logic chk, input logic [7:0] exp);
    @(posedge clk_in);
    #1;
    ram_rw_in   = rw;
    ram_addr_in = addr;
    ram_data_in = data;
    rdTag       = chk;
    if (chk) rdQ.push_back('{addr: addr, data: exp});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic ramWrite(input logic [31:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 8'h00);
  endtask

  task automatic ramRead(input logic [31:0] addr, input logic [7:0] exp);
    applyStimulus(1'b0, addr, 8'h00, 1'b1, exp);
  endtask

  task automatic txPush(input logic [7:0] data, input logic accepted);
    applyStimulus(1'b1, IoBase, data, 1'b0, 8'h00);
    if (accepted) txQ.push_back(data);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      idle();
      if (txQ.size() == 0) break;
    end
    checkOutput("drainDone", txQ.size(), 0);
  endtask

  // The monitor pops expectations when the DUT presents read data or completes a TX handshake.
  always @(negedge clk_in) begin
    if (rst_in) begin
      rdPending = 1'b0;
    end else begin
      if (rdPending) begin
        if (rdQ.size() == 0) begin
          checkOutput("rdQueueUnderflow", 1, 0);
        end else begin
          rdExp_t e;
          e = rdQ.pop_front();
          checkOutput($sformatf("ramRead@%0h", e.addr), ram_data_out, e.data);
        end
      end
      rdPending = rdTag && rdy_in;
      if (tx_valid_out && tx_ready_in && rdy_in) begin
        if (txQ.size() == 0) checkOutput("txUnexpectedByte", tx_data_out, 32'hFFFF_FFFF);
        else checkOutput("txByte", tx_data_out, txQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready_in = 1'b0;
    ram_rw_in = 1'b0; ram_addr_in = 32'h0; ram_data_in = 8'h00;
    rdTag = 1'b0; rdPending = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("resetRamData", ram_data_out, 8'h00);
    checkOutput("resetTxValid", tx_valid_out, 0);
    checkOutput("resetTxData", tx_data_out, 8'h00);
    rst_in = 1'b0;

    // Basic RAM write and read
    ramWrite(32'h10, 8'hA5);
    ramRead(32'h10, 8'hA5);
    // Address wrap, the I/O data read, status when empty, and an unmapped offset
    ramWrite(32'h20004, 8'h3C);
    ramRead(32'h4, 8'h3C);
    ramRead(IoBase, 8'h00);
    ramRead(IoBase + 4, 8'h20);
    ramRead(IoBase + 2, 8'h00);

    // Overfill the FIFO, then check status, clear overflow, and drain
    for (int i = 0; i < 17; i++) txPush(8'(i), i < 16);
    ramRead(IoBase + 4, 8'hC0);
    ramWrite(IoBase + 4, 8'hFF);
    ramRead(IoBase + 4, 8'h40);
    idle();
    tx_ready_in = 1'b1;
    waitDrain(64);
    tx_ready_in = 1'b0;
    idle();
    checkOutput("txEmptyAfterDrain", tx_valid_out, 0);

    // Push and pop together while the FIFO is full
    for (int i = 0; i < 16; i++) txPush(8'h20 + 8'(i), 1'b1);
    txPush(8'h77, 1'b1);
    tx_ready_in = 1'b1;
    idle();
    tx_ready_in = 1'b0;
    ramRead(IoBase + 4, 8'h40);
    tx_ready_in = 1'b1;
    waitDrain(64);
    tx_ready_in = 1'b0;

    // With rdy_in low, RAM, the FIFO and ram_data_out all hold
    ramWrite(32'h40, 8'h11);
    txPush(8'h55, 1'b1);
    ramRead(32'h10, 8'hA5);
    applyStimulus(1'b1, 32'h40, 8'h99, 1'b0, 8'h00);
    rdy_in = 1'b0;
    tx_ready_in = 1'b1;
    repeat (3) idle();
    checkOutput("holdTxValid", tx_valid_out, 1);
    checkOutput("holdTxData", tx_data_out, 8'h55);
    checkOutput("holdRamData", ram_data_out, 8'hA5);
    idle();
    rdy_in = 1'b1;
    idle();
    tx_ready_in = 1'b0;
    ramRead(32'h40, 8'h11);
    idle();
    checkOutput("txEmptyAfterHold", tx_valid_out, 0);

    // Reset mid-cycle while bytes are queued
    ramWrite(32'h80, 8'h5A);
    txPush(8'h01, 1'b1);
    txPush(8'h02, 1'b1);
    txPush(8'h03, 1'b1);
    idle();
    #1;
    rst_in = 1'b1;
    #1;
    checkOutput("midResetTxValid", tx_valid_out, 0);
    checkOutput("midResetTxData", tx_data_out, 8'h00);
    checkOutput("midResetRamData", ram_data_out, 8'h00);
    txQ.delete();
    rdQ.delete();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    ramRead(32'h80, 8'h5A);
    ramRead(32'h10, 8'hA5);
    ramRead(IoBase + 4, 8'h20);

`ifdef RAM_RESPONDER_STATS_EN
    // Stat counters: clear them, then count a known mix of transactions
    ramWrite(IoBase + 8, 8'h00);
    ramRead(32'h10, 8'hA5);
    ramRead(32'h80, 8'h5A);
    ramWrite(32'h90, 8'h01);
    txPush(8'h66, 1'b1);
    ramRead(IoBase + 8, 8'h02);
    ramRead(IoBase + 9, 8'h00);
    ramRead(IoBase + 10, 8'h01);
    ramRead(IoBase + 12, 8'h01);
    idle();
    rdy_in = 1'b0;
    repeat (4) idle();
    ramRead(IoBase + 8, 8'h02);
    rdy_in = 1'b1;
    ramRead(IoBase + 10, 8'h01);
    ramRead(IoBase + 12, 8'h01);
    ramRead(IoBase + 11, 8'h00);
    tx_ready_in = 1'b1;
    waitDrain(16);
    tx_ready_in = 1'b0;
`endif

    idle();
    idle();
    checkOutput("rdQueueEmpty", rdQ.size(), 0);
    checkOutput("txQueueEmpty", txQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
